// File: rtl/uart_param_if.sv
// uart_param_if
//   Bundles the parameter bank input and the serial-link outputs of the
//   parameter transmitter.
//   Ports (signals):
//     en           enable; low holds the transmitter in its reset state
//     param_values packed bank, key k at [10k+9:10k]
//     uart_dout    serial TX line, idle high, 8N1, LSB first
//     busy         high while a frame is on the line
//     frame_sent   1-cycle pulse when the stop bit of byte1 completes
//     dbg_state    current transmitter FSM state (observability only)
//   Modports: master = the side that supplies parameters and observes the
//   line; slave = the transmitter.
//
//   Handshake: there is no valid/ready pair. param_values is a level-sampled
//   bank that the transmitter reads whenever it visits an index; the line has
//   no flow control, and frame_sent/busy are status outputs only.
interface uart_param_if #(
  parameter int NUM_PARAMS = 13
);
  logic                    en;
  logic [10*NUM_PARAMS-1:0] param_values;
  logic                    uart_dout;
  logic                    busy;
  logic                    frame_sent;
  logic [1:0]              dbg_state;

  modport master (
    output en, param_values,
    input  uart_dout, busy, frame_sent, dbg_state
  );

  modport slave (
    input  en, param_values,
    output uart_dout, busy, frame_sent, dbg_state
  );
endinterface

// File: rtl/uart_param_transmitter.sv
// uart_param_transmitter
//   Serializes a bank of 10-bit parameters onto a UART line as 2-byte frames:
//     byte0 = {2'b00, key[3:0], value[9:8]}, byte1 = value[7:0].
//   Only parameters that moved by at least THRESHOLD since last sent are
//   transmitted; after reset or enable the whole bank is sent once.
//   Ports:
//     clk  system clock
//     rst  synchronous active-high reset
//     bus  uart_param_if.slave (en, param_values in; uart_dout, busy,
//          frame_sent, dbg_state out)
//   Optional feature: define PARAM_TX_KEEPALIVE_EN to mark the whole bank
//   dirty every KEEPALIVE_CYCLES cycles (periodic full refresh).
module uart_param_transmitter #(
  parameter int CLK_FREQ         = 100000000,
  parameter int BAUD_RATE        = 1500000,
  parameter int NUM_PARAMS       = 13,
  parameter int THRESHOLD        = 1,
  parameter int KEEPALIVE_CYCLES = 100000000
) (
  input logic        clk,
  input logic        rst,
  uart_param_if.slave bus
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int BAUD_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [3:0]        LAST_IDX  = 4'(NUM_PARAMS - 1);
  localparam logic signed [10:0] THRESH   = 11'(THRESHOLD);

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    BYTE0 = 2'd1,
    BYTE1 = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             scan_idx_q, scan_idx_d;
  logic [9:0]             tx_value_q, tx_value_d;
  logic [BAUD_W-1:0]      baud_cnt_q, baud_cnt_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [NUM_PARAMS-1:0]  dirty_q, dirty_d;
  logic [9:0]             shadow_q [NUM_PARAMS];
  logic                   uart_dout_q, uart_dout_d;
  logic                   busy_q, busy_d;
  logic                   frame_sent_q, frame_sent_d;

  logic                   soft_rst;
  logic [9:0]             param_arr [NUM_PARAMS];
  logic [9:0]             cur_value;
  logic signed [10:0]     diff, diff_mag;
  logic                   qualify;
  logic                   shadow_we;
  logic                   bit_tick;
  logic [3:0]             next_idx;
  logic [9:0]             frame_bits;

  assign soft_rst = rst | ~bus.en;

  for (genvar k = 0; k < NUM_PARAMS; k++) begin : g_unpack
    assign param_arr[k] = bus.param_values[10*k +: 10];
  end

  // Difference is taken on 11 bits so the full 0..1023 range never overflows.
  assign cur_value = param_arr[scan_idx_q];
  assign diff      = $signed({1'b0, cur_value}) - $signed({1'b0, shadow_q[scan_idx_q]});
  assign diff_mag  = diff[10] ? -diff : diff;
  assign qualify   = dirty_q[scan_idx_q] | (diff_mag >= THRESH);
  assign bit_tick  = (baud_cnt_q == BAUD_LAST);
  assign next_idx  = (scan_idx_q == LAST_IDX) ? 4'd0 : scan_idx_q + 4'd1;

`ifdef PARAM_TX_KEEPALIVE_EN
  localparam int KA_W = (KEEPALIVE_CYCLES > 1) ? $clog2(KEEPALIVE_CYCLES) : 1;
  logic [KA_W-1:0] ka_cnt_q;
  logic            ka_fire;

  assign ka_fire = (ka_cnt_q == KA_W'(KEEPALIVE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (soft_rst || ka_fire) ka_cnt_q <= '0;
    else                     ka_cnt_q <= ka_cnt_q + 1'b1;
  end
`endif

  always_comb begin
    state_d      = state_q;
    scan_idx_d   = scan_idx_q;
    tx_value_d   = tx_value_q;
    baud_cnt_d   = baud_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    dirty_d      = dirty_q;
    frame_sent_d = 1'b0;
    shadow_we    = 1'b0;
    frame_bits   = 10'h3ff;

    case (state_q)
      SCAN: begin
        if (qualify) begin
          state_d              = BYTE0;
          tx_value_d           = cur_value;
          shadow_we            = 1'b1;
          dirty_d[scan_idx_q]  = 1'b0;
          baud_cnt_d           = '0;
          bit_cnt_d            = 4'd0;
        end else begin
          scan_idx_d = next_idx;
        end
      end
      BYTE0, BYTE1: begin
        if (!bit_tick) begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end else begin
          baud_cnt_d = '0;
          if (bit_cnt_q != 4'd9) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else begin
            bit_cnt_d = 4'd0;
            if (state_q == BYTE0) begin
              state_d = BYTE1;
            end else begin
              // scan_idx still holds the key just sent; resume after it.
              state_d      = SCAN;
              frame_sent_d = 1'b1;
              scan_idx_d   = next_idx;
            end
          end
        end
      end
      default: state_d = SCAN;
    endcase

`ifdef PARAM_TX_KEEPALIVE_EN
    // Refresh wins over the clear of the index being latched this cycle.
    if (ka_fire) dirty_d = '1;
`endif

    // Line level is registered: compute the bit that the next state emits.
    // Layout per byte is {stop, data[7:0], start}, indexed by bit_cnt.
    if (state_d == BYTE0)
      frame_bits = {1'b1, 2'b00, scan_idx_d, tx_value_d[9:8], 1'b0};
    else if (state_d == BYTE1)
      frame_bits = {1'b1, tx_value_d[7:0], 1'b0};
    uart_dout_d = (state_d == SCAN) ? 1'b1 : frame_bits[bit_cnt_d];
    busy_d      = (state_d != SCAN);
  end

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      state_q      <= SCAN;
      scan_idx_q   <= 4'd0;
      tx_value_q   <= 10'd0;
      baud_cnt_q   <= '0;
      bit_cnt_q    <= 4'd0;
      dirty_q      <= '1;
      uart_dout_q  <= 1'b1;
      busy_q       <= 1'b0;
      frame_sent_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      scan_idx_q   <= scan_idx_d;
      tx_value_q   <= tx_value_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      dirty_q      <= dirty_d;
      uart_dout_q  <= uart_dout_d;
      busy_q       <= busy_d;
      frame_sent_q <= frame_sent_d;
    end
  end

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      for (int k = 0; k < NUM_PARAMS; k++) shadow_q[k] <= 10'd0;
    end else if (shadow_we) begin
      shadow_q[scan_idx_q] <= cur_value;
    end
  end

  assign bus.uart_dout  = uart_dout_q;
  assign bus.busy       = busy_q;
  assign bus.frame_sent = frame_sent_q;
  assign bus.dbg_state  = state_q;

endmodule
